// File: rtl/shbus_arb4.sv
// Four-requester round-robin arbiter for the shared buffered data path.
// Holds a one-hot grant for a burst fixed at grant time, with sink backpressure.
//
// state | meaning
// IDLE  | no grant; pick next winner from req in round-robin order
// XFER  | granted requester drives the bus until its last beat is accepted
module shbus_arb4 #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic                  clk_sys,
  input  logic                  rst_n,
  input  logic [3:0]            req,
  input  logic [4*LEN_W-1:0]    req_len,
  input  logic [4*DATA_W-1:0]   req_data,
  output logic [3:0]            gnt,
  output logic [3:0]            beat_ack,
  output logic                  bus_vld,
  output logic [DATA_W-1:0]     bus_data,
  output logic                  bus_last,
  input  logic                  bus_rdy,
  output logic                  busy
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_XFER = 1'b1;

  localparam logic [LEN_W-1:0] CNT_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  logic             state;
  logic [LEN_W-1:0] cnt;
  logic [1:0]       ptr;
  logic [1:0]       cur;

  logic             win_any;
  logic [1:0]       win_idx;
  logic [1:0]       cand;
  logic [LEN_W-1:0] win_len;
  logic             xfer;
  logic             accept;
  logic             cnt_zero;

  // Search ptr+1, ptr+2, ptr+3, then ptr itself; first requesting index wins.
  always_comb begin
    win_any = 1'b0;
    win_idx = ptr;
    cand    = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr + 2'(k);
      if (!win_any && req[cand]) begin
        win_any = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign win_len  = req_len[win_idx*LEN_W +: LEN_W];
  assign xfer     = (state == ST_XFER);
  assign accept   = xfer && bus_rdy;
  assign cnt_zero = (cnt == '0);

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      gnt   <= '0;
      cnt   <= '0;
      ptr   <= 2'd3;
      cur   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_any) begin
            gnt   <= 4'b0001 << win_idx;
            cnt   <= win_len;
            cur   <= win_idx;
            state <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (accept) begin
            if (cnt_zero) begin
              gnt   <= '0;
              ptr   <= cur;
              state <= ST_IDLE;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

  // AND-OR steering keeps the bus at zero whenever no grant is held.
  always_comb begin
    bus_data = '0;
    for (int i = 0; i < 4; i++) begin
      bus_data = bus_data | (req_data[i*DATA_W +: DATA_W] & {DATA_W{gnt[i]}});
    end
  end

  assign beat_ack = accept ? gnt : 4'b0000;
  assign bus_vld  = xfer;
  assign busy     = xfer;
  assign bus_last = xfer && cnt_zero;

endmodule

// File: tb/tb_shbus_arb4.sv
// Self-checking bench for shbus_arb4: scoreboard of expected beats checked
// by a bus monitor, plus per-scenario inline checks of timing and control.
module tb_shbus_arb4;

  localparam int DATA_W = 32;
  localparam int LEN_W  = 4;

  logic                clk_sys;
  logic                rst_n;
  logic [3:0]          req;
  logic [4*LEN_W-1:0]  req_len;
  logic [4*DATA_W-1:0] req_data;
  logic [3:0]          gnt;
  logic [3:0]          beat_ack;
  logic                bus_vld;
  logic [DATA_W-1:0]   bus_data;
  logic                bus_last;
  logic                bus_rdy;
  logic                busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]        r;
    logic [DATA_W-1:0] d;
    logic              last;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   wc[4] = '{0, 0, 0, 0};

  shbus_arb4 #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .req      (req),
    .req_len  (req_len),
    .req_data (req_data),
    .gnt      (gnt),
    .beat_ack (beat_ack),
    .bus_vld  (bus_vld),
    .bus_data (bus_data),
    .bus_last (bus_last),
    .bus_rdy  (bus_rdy),
    .busy     (busy)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  function automatic logic [DATA_W-1:0] word(int r, int n);
    logic [23:0] lo;
    lo = n[23:0];
    return {8'hA0 + 8'(r), lo};
  endfunction

  function automatic void push_burst(int r, int first, int beats);
    exp_t e;
    for (int k = 0; k < beats; k++) begin
      e.r    = 2'(r);
      e.d    = word(r, first + k);
      e.last = (k == beats - 1);
      sb.push_back(e);
    end
  endfunction

  // Each requester presents a fresh word after every beat_ack.
  always_comb begin
    req_data = '0;
    for (int i = 0; i < 4; i++) req_data[i*DATA_W +: DATA_W] = word(i, wc[i]);
  end

  always @(posedge clk_sys) begin
    for (int i = 0; i < 4; i++) if (beat_ack[i]) wc[i] = wc[i] + 1;
  end

  always @(negedge clk_sys) begin
    if (rst_n && bus_vld && bus_rdy) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: gnt=%b data=%h last=%b, no beat expected", gnt, bus_data, bus_last);
      end else begin
        mon_e = sb.pop_front();
        if (gnt !== (4'b0001 << mon_e.r) || bus_data !== mon_e.d ||
            bus_last !== mon_e.last || beat_ack !== gnt) begin
          errors++;
          $display("FAIL beat: got gnt=%b data=%h last=%b ack=%b, want gnt=%b data=%h last=%b ack=gnt",
                   gnt, bus_data, bus_last, beat_ack, 4'b0001 << mon_e.r, mon_e.d, mon_e.last);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; req = '0; req_len = '0; bus_rdy = 1'b0;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    checks++;
    if ({gnt, beat_ack, bus_vld, bus_last, busy} !== 11'b0 || bus_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b ack=%b vld=%b last=%b busy=%b data=%h, want all 0",
               gnt, beat_ack, bus_vld, bus_last, busy, bus_data);
    end
    @(posedge clk_sys); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    @(posedge clk_sys); #1;
    push_burst(0, wc[0], 1);
    req = 4'b0001; req_len = '0; bus_rdy = 1'b1;
    @(negedge clk_sys);
    checks++;
    if (gnt !== 4'b0000) begin errors++; $display("FAIL single_pre_gnt: gnt=%b want 0000", gnt); end
    @(posedge clk_sys); #1;
    req = 4'b0000;
    @(negedge clk_sys);
    checks++;
    if (gnt !== 4'b0001 || !bus_vld || !bus_last || beat_ack !== 4'b0001 || !busy) begin
      errors++;
      $display("FAIL single_grant: gnt=%b vld=%b last=%b ack=%b busy=%b, want 0001 1 1 0001 1",
               gnt, bus_vld, bus_last, beat_ack, busy);
    end
    @(negedge clk_sys);
    checks++;
    if (bus_vld || busy || gnt !== 4'b0000) begin
      errors++;
      $display("FAIL single_idle: vld=%b busy=%b gnt=%b, want 0 0 0000", bus_vld, busy, gnt);
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL single_drain: %0d beats pending, want 0", sb.size()); end
  endtask

  task automatic test_round_robin();
    @(posedge clk_sys); #1;
    rst_n = 1'b0;
    @(posedge clk_sys); #1;
    rst_n = 1'b1;
    push_burst(0, wc[0], 2);
    push_burst(1, wc[1], 2);
    push_burst(2, wc[2], 2);
    push_burst(3, wc[3], 2);
    push_burst(0, wc[0] + 2, 2);
    req = 4'b1111; req_len = {4{4'd1}}; bus_rdy = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk_sys);
      @(negedge clk_sys);
      checks++;
      if (bus_vld !== (k % 3 != 2)) begin
        errors++;
        $display("FAIL rr_duty cycle %0d: vld=%b want %b", k, bus_vld, (k % 3 != 2));
      end
      if (k == 14) req = 4'b0000;
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL rr_drain: %0d beats pending, want 0", sb.size()); end
  endtask

  task automatic test_rdy_toggle();
    int acks = 0;
    logic stalled = 1'b0;
    logic [DATA_W-1:0] s_data = '0;
    logic s_last = 1'b0;
    @(posedge clk_sys); #1;
    push_burst(2, wc[2], 4);
    req = 4'b0100; req_len = 16'h0300; bus_rdy = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk_sys); #1;
      req = 4'b0000;
      bus_rdy = ~bus_rdy;
      @(negedge clk_sys);
      if (stalled) begin
        checks++;
        if (bus_data !== s_data || bus_last !== s_last) begin
          errors++;
          $display("FAIL stall_hold: data=%h last=%b, want %h %b", bus_data, bus_last, s_data, s_last);
        end
      end
      stalled = bus_vld && !bus_rdy;
      if (stalled) begin
        s_data = bus_data; s_last = bus_last;
        checks++;
        if (beat_ack !== 4'b0000) begin errors++; $display("FAIL stall_ack: ack=%b want 0000", beat_ack); end
      end
      if (beat_ack[2]) acks++;
    end
    bus_rdy = 1'b1;
    checks++;
    if (acks != 4 || sb.size() != 0) begin
      errors++;
      $display("FAIL toggle_acks: acks=%0d pending=%0d, want 4 and 0", acks, sb.size());
    end
  endtask

  task automatic test_len_change();
    int acks = 0;
    @(posedge clk_sys); #1;
    push_burst(1, wc[1], 3);
    req = 4'b0010; req_len = 16'h0020; bus_rdy = 1'b1;
    @(posedge clk_sys); #1;
    req = 4'b0000; req_len = 16'h0090;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk_sys);
      if (beat_ack[1]) acks++;
    end
    checks++;
    if (acks != 3 || sb.size() != 0 || busy) begin
      errors++;
      $display("FAIL len_fixed: acks=%0d pending=%0d busy=%b, want 3 0 0", acks, sb.size(), busy);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk_sys); #1;
    push_burst(2, wc[2], 1);
    sb[0].last = 1'b0;
    req = 4'b0100; req_len = 16'h0300; bus_rdy = 1'b1;
    @(posedge clk_sys); #1;
    req = 4'b0000;
    @(posedge clk_sys); #1;
    rst_n = 1'b0;
    @(posedge clk_sys);
    @(negedge clk_sys);
    checks++;
    if (gnt !== 4'b0000 || bus_vld || busy || beat_ack !== 4'b0000 || bus_last || bus_data !== '0) begin
      errors++;
      $display("FAIL mid_reset: gnt=%b vld=%b busy=%b ack=%b last=%b data=%h, want all 0",
               gnt, bus_vld, busy, beat_ack, bus_last, bus_data);
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL mid_reset_beats: %0d pending, want 0", sb.size()); end
    push_burst(0, wc[0], 1);
    req = 4'b1111; req_len = '0; rst_n = 1'b1;
    @(posedge clk_sys); #1;
    req = 4'b0000;
    @(negedge clk_sys);
    checks++;
    if (gnt !== 4'b0001) begin errors++; $display("FAIL post_reset_gnt: gnt=%b want 0001", gnt); end
    @(negedge clk_sys);
    checks++;
    if (bus_vld || sb.size() != 0) begin
      errors++;
      $display("FAIL post_reset_idle: vld=%b pending=%0d, want 0 0", bus_vld, sb.size());
    end
  endtask

  task automatic test_max_len();
    int acks = 0;
    @(posedge clk_sys); #1;
    push_burst(3, wc[3], 16);
    req = 4'b1000; req_len = 16'hF000; bus_rdy = 1'b1;
    @(posedge clk_sys); #1;
    req = 4'b0000;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_sys);
      if (beat_ack[3]) acks++;
    end
    checks++;
    if (acks != 16 || sb.size() != 0 || busy) begin
      errors++;
      $display("FAIL max_len: acks=%0d pending=%0d busy=%b, want 16 0 0", acks, sb.size(), busy);
    end
    @(posedge clk_sys); #1;
    push_burst(0, wc[0], 1);
    req = 4'b1001; req_len = '0;
    @(posedge clk_sys); #1;
    req = 4'b0000;
    @(negedge clk_sys);
    checks++;
    if (gnt !== 4'b0001) begin errors++; $display("FAIL after_max_gnt: gnt=%b want 0001", gnt); end
    repeat (3) @(negedge clk_sys);
    checks++;
    if (sb.size() != 0 || bus_vld) begin
      errors++;
      $display("FAIL after_max_drain: pending=%0d vld=%b, want 0 0", sb.size(), bus_vld);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_rdy_toggle();
    test_len_change();
    test_reset_mid();
    test_max_len();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
